// File: rtl/instr_queue_pkg.sv
// Shared constants for the fetch/decode boundary: reset PC, the NOP word,
// and the width of one buffered {pc, instr} entry.
package instr_queue_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam int          IQ_ENTRY_W = 64;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// The slave modport is the queue itself; the master modport is its environment.
interface instr_queue_if #(
  parameter int DEPTH = 4
);
  import instr_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/instr_queue_storage.sv
// Entry array for the instruction queue: one synchronous write port, one
// asynchronous read port, and deliberately no reset on the contents.
module iq_storage
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [IQ_ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [IQ_ENTRY_W-1:0] rdata_o
);

  logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// Prefetch queue between fetch and decode: a DEPTH-entry circular buffer
// with valid/ready on both sides and a flush that drops everything buffered.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  instr_queue_if.slave  iq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  notFull, notEmpty;
  logic                  push, pop, writeEn;
  logic [IQ_ENTRY_W-1:0] headEntry;

  // Handshake flags come only from registered occupancy, never from inputs.
  assign notFull  = (count_q != FULL);
  assign notEmpty = (count_q != '0);
  assign push     = iq.in_valid && notFull;
  assign pop      = iq.out_ready && notEmpty;
  assign writeEn  = push && !iq.flush && !Reset;

  // Flush wins over any push or pop presented in the same cycle.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (iq.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wp_d = wp_q + PW'(1);
      end
      if (pop) begin
        rp_d = rp_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  iq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .Clk     (Clk),
    .we_i    (writeEn),
    .waddr_i (wp_q),
    .wdata_i ({iq.in_pc, iq.in_instr}),
    .raddr_i (rp_q),
    .rdata_o (headEntry)
  );

  // An empty queue shows forced reset values rather than stale array data.
  assign iq.in_ready  = notFull;
  assign iq.out_valid = notEmpty;
  assign iq.out_pc    = notEmpty ? headEntry[IQ_ENTRY_W-1:32] : PC_RESET;
  assign iq.out_instr = notEmpty ? headEntry[31:0] : NOP;
  assign iq.count     = count_q;

endmodule
